// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, instruction field positions
// and the decoded-bundle layout passed from the field decoder to the output register.
package decode_pkg;

   localparam int INSTR_SIZE       = 32;
   localparam int REG_ADDRESS_SIZE = 5;
   localparam int NUM_REGS         = 32;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 25;
   localparam int RD_MSB  = 24;
   localparam int RD_LSB  = 20;
   localparam int R1_MSB  = 19;
   localparam int R1_LSB  = 15;
   localparam int R2_MSB  = 14;
   localparam int R2_LSB  = 10;
   localparam int IMM15_MSB  = 14;
   localparam int IMMS_LO_MSB = 9;
   localparam int IMM20_MSB  = 19;

   typedef enum logic [6:0] {
      OP_ADD  = 7'h00,
      OP_SUB  = 7'h01,
      OP_MUL  = 7'h02,
      OP_LDW  = 7'h10,
      OP_LDB  = 7'h11,
      OP_STW  = 7'h12,
      OP_STB  = 7'h13,
      OP_MOV  = 7'h14,
      OP_BEQ  = 7'h30,
      OP_JUMP = 7'h31
   } opcode_e;

   // Immediate is carried pre-extended to 32 bits; the stage widens it further.
   typedef struct packed {
      logic [6:0]                  opcode;
      logic                        register_write;
      logic [REG_ADDRESS_SIZE-1:0] addr_r1;
      logic [REG_ADDRESS_SIZE-1:0] addr_r2;
      logic [REG_ADDRESS_SIZE-1:0] addr_rd;
      logic [31:0]                 imm;
      logic                        illegal;
   } decoded_t;

   localparam int DECODED_W = $bits(decoded_t);

   function automatic logic [31:0] sext15(input logic [14:0] v);
      return {{17{v[14]}}, v};
   endfunction

   function automatic logic [31:0] sext20(input logic [19:0] v);
      return {{12{v[19]}}, v};
   endfunction

endpackage

// File: rtl/decode_stage_instr_field_decode.sv
// Purely combinational instruction-to-bundle decoder; unused register fields
// are reported as 0 and writes to r0 are suppressed here.
module instr_field_decode
   import decode_pkg::*;
(
   input  logic [INSTR_SIZE-1:0] instruction,
   output logic [DECODED_W-1:0]  bundle
);

   logic [6:0]                  op_f;
   logic [REG_ADDRESS_SIZE-1:0] rd_f;
   logic [REG_ADDRESS_SIZE-1:0] r1_f;
   logic [REG_ADDRESS_SIZE-1:0] r2_f;
   logic [14:0]                 imm15_f;
   logic [14:0]                 imms_f;
   logic [19:0]                 imm20_f;
   decoded_t                    dec;

   assign op_f    = instruction[OP_MSB:OP_LSB];
   assign rd_f    = instruction[RD_MSB:RD_LSB];
   assign r1_f    = instruction[R1_MSB:R1_LSB];
   assign r2_f    = instruction[R2_MSB:R2_LSB];
   assign imm15_f = instruction[IMM15_MSB:0];
   assign imms_f  = {instruction[RD_MSB:RD_LSB], instruction[IMMS_LO_MSB:0]};
   assign imm20_f = instruction[IMM20_MSB:0];

   always_comb begin
      dec        = '0;
      dec.opcode = op_f;
      case (op_f)
         OP_ADD, OP_SUB, OP_MUL: begin
            dec.register_write = 1'b1;
            dec.addr_rd        = rd_f;
            dec.addr_r1        = r1_f;
            dec.addr_r2        = r2_f;
         end
         OP_LDW, OP_LDB: begin
            dec.register_write = 1'b1;
            dec.addr_rd        = rd_f;
            dec.addr_r1        = r1_f;
            dec.imm            = sext15(imm15_f);
         end
         OP_STW, OP_STB, OP_BEQ: begin
            dec.addr_r1 = r1_f;
            dec.addr_r2 = r2_f;
            dec.imm     = sext15(imms_f);
         end
         OP_MOV: begin
            dec.register_write = 1'b1;
            dec.addr_rd        = rd_f;
            dec.imm            = sext20(imm20_f);
         end
         OP_JUMP: begin
            dec.addr_r1 = r1_f;
            dec.imm     = sext15(imm15_f);
         end
         default: dec.illegal = 1'b1;
      endcase
      // r0 is hard-wired, so a write to it must never mark a pending result.
      if (dec.addr_rd == '0) begin
         dec.register_write = 1'b0;
      end
   end

   assign bundle = dec;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready output register plus a pending-write
// scoreboard that holds back instructions reading registers still in flight.
module decode_stage
   import decode_pkg::*;
#(
   parameter int ADDRESS_SIZE  = 32,
   parameter int SCOREBOARD_EN = 1
)
(
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [INSTR_SIZE-1:0]       instruction,
   input  logic                        flush,
   input  logic                        wb_valid,
   input  logic [REG_ADDRESS_SIZE-1:0] wb_addr,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [6:0]                  out_opcode,
   output logic                        out_register_write,
   output logic [REG_ADDRESS_SIZE-1:0] out_addr_r1,
   output logic [REG_ADDRESS_SIZE-1:0] out_addr_r2,
   output logic [REG_ADDRESS_SIZE-1:0] out_addr_rd,
   output logic [ADDRESS_SIZE-1:0]     out_immediate,
   output logic                        out_illegal
);

   logic [DECODED_W-1:0] dec_bits;
   decoded_t             dec;
   decoded_t             bundle_q, bundle_d;
   logic                 out_valid_q, out_valid_d;
   logic [NUM_REGS-1:0]  pending_q, pending_d;
   logic [NUM_REGS-1:0]  wb_clr, flush_clr, set_mask, pending_eff;
   logic                 hazard;
   logic                 accept;
   logic [ADDRESS_SIZE-1:0] imm_ext;

   instr_field_decode u_field_decode (
      .instruction (instruction),
      .bundle      (dec_bits)
   );

   assign dec = decoded_t'(dec_bits);

   always_comb begin
      wb_clr    = '0;
      flush_clr = '0;
      set_mask  = '0;
      if (wb_valid) begin
         wb_clr[wb_addr] = 1'b1;
      end
      if (flush && out_valid_q && bundle_q.register_write) begin
         flush_clr[bundle_q.addr_rd] = 1'b1;
      end
      if (accept && dec.register_write) begin
         set_mask[dec.addr_rd] = 1'b1;
      end
   end

   // A write-back landing this cycle releases its dependants immediately.
   assign pending_eff = pending_q & ~wb_clr;
   assign hazard = (SCOREBOARD_EN != 0) &&
                   (((dec.addr_r1 != '0) && pending_eff[dec.addr_r1]) ||
                    ((dec.addr_r2 != '0) && pending_eff[dec.addr_r2]));

   assign in_ready = !flush && (!out_valid_q || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   generate
      if (SCOREBOARD_EN != 0) begin : g_sb
         for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign pending_d[gi] = set_mask[gi] |
                                   (pending_q[gi] & ~wb_clr[gi] & ~flush_clr[gi]);
         end
      end else begin : g_nosb
         assign pending_d = '0;
      end
   endgenerate

   always_comb begin
      out_valid_d = out_valid_q;
      bundle_d    = bundle_q;
      if (accept) begin
         out_valid_d = 1'b1;
         bundle_d    = dec;
      end else if (flush || out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
         pending_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
         pending_q   <= pending_d;
      end
   end

   always_comb begin
      imm_ext       = {ADDRESS_SIZE{bundle_q.imm[31]}};
      imm_ext[31:0] = bundle_q.imm;
   end

   assign out_valid          = out_valid_q;
   assign out_opcode         = bundle_q.opcode;
   assign out_register_write = bundle_q.register_write;
   assign out_addr_r1        = bundle_q.addr_r1;
   assign out_addr_r2        = bundle_q.addr_r2;
   assign out_addr_rd        = bundle_q.addr_rd;
   assign out_immediate      = imm_ext;
   assign out_illegal        = bundle_q.illegal;

endmodule
